mem_arbiter: RTL and testbench

- Parametrised, N-channel successor to the two-client memory controller.
- Arbitrates NCH independent 1/2/4-byte read/write requesters (icache, LSB, future prefetch/DMA) onto the single byte-serial RAM/IO bus.
- Grants by round-robin, honours UART back-pressure on IO writes, and aborts flushable reads on jump_flag.
- Sits between the fetch/LSB units and the top-level mem_* pins.

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin N-channel arbiter onto a byte-serial RAM/IO bus
module mem_arbiter #(
  parameter int NCH = 2,
  parameter logic [NCH-1:0] FLUSH_MASK = {NCH{1'b1}},
  parameter logic [1:0] IO_BASE_HI = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_flag,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH-1:0]    req_wr,
  input  logic [NCH*32-1:0] req_addr,
  input  logic [NCH*32-1:0] req_wdata,
  input  logic [NCH*3-1:0]  req_size,
  output logic [NCH-1:0]    done,
  output logic [31:0]       rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [31:0]       mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_IO, XFER, DONE} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_rr, r_ch, w_gnt;
  logic            r_wr, r_hold, w_any, w_wr, w_flush;
  logic [31:0]     r_addr, r_wdata, w_addr, w_wdata;
  logic [2:0]      r_n, r_k, w_n, w_sz;
  logic [1:0]      w_kprev, w_knext;
  logic [NCH-1:0]  w_cand;
  // a pending flush hides flushable reads from arbitration
  assign w_cand = req_valid & ~({NCH{jump_flag}} & FLUSH_MASK & ~req_wr);
  always_comb begin
    w_any = |w_cand;
    w_gnt = r_rr;
    for (int j = NCH; j >= 1; j--)
      if (w_cand[CW'((int'(r_rr) + j) % NCH)]) w_gnt = CW'((int'(r_rr) + j) % NCH);
  end
  assign w_wr    = req_wr[w_gnt];
  assign w_addr  = req_addr[32*w_gnt +: 32];
  assign w_wdata = req_wdata[32*w_gnt +: 32];
  assign w_sz    = req_size[3*w_gnt +: 3];
  assign w_n     = (w_sz == 3'd1) ? 3'd1 : (w_sz == 3'd2) ? 3'd2 : 3'd4;
  assign w_kprev = 2'(r_k - 3'd1);
  assign w_knext = 2'(r_k + 3'd1);
  assign w_flush = jump_flag & ~r_wr & FLUSH_MASK[r_ch];
  // r_hold remembers a write beat whose mem_wr was masked by rdy=0 so it is re-driven
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr <= '0;
      r_ch <= '0;
      r_wr <= 1'b0;
      r_hold <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_n <= '0;
      r_k <= '0;
      done <= '0;
      rdata <= '0;
      mem_a <= '0;
      mem_dout <= '0;
      mem_wr <= 1'b0;
    end else if (!rdy) begin
      mem_wr <= 1'b0;
    end else if (r_hold && !mem_wr) begin
      mem_wr <= 1'b1;
    end else begin
      done <= '0;
      case (r_state)
        IDLE: begin
          mem_a <= '0;
          mem_wr <= 1'b0;
          r_hold <= 1'b0;
          if (w_any) begin
            r_ch <= w_gnt;
            r_rr <= w_gnt;
            r_wr <= w_wr;
            r_addr <= w_addr;
            r_wdata <= w_wdata;
            r_n <= w_n;
            r_k <= '0;
            rdata <= '0;
            if (w_wr && w_addr[17:16] == IO_BASE_HI && io_buffer_full) begin
              r_state <= WAIT_IO;
            end else begin
              r_state <= XFER;
              mem_a <= w_addr;
              mem_dout <= w_wdata[7:0];
              mem_wr <= w_wr;
              r_hold <= w_wr;
            end
          end
        end
        WAIT_IO: begin
          if (!io_buffer_full) begin
            r_state <= XFER;
            mem_a <= r_addr;
            mem_dout <= r_wdata[7:0];
            mem_wr <= 1'b1;
            r_hold <= 1'b1;
          end
        end
        XFER: begin
          if (w_flush) begin
            r_state <= IDLE;
            mem_a <= '0;
            mem_wr <= 1'b0;
            r_hold <= 1'b0;
          end else if (r_wr) begin
            if (r_k == r_n - 3'd1) begin
              r_state <= DONE;
              done[r_ch] <= 1'b1;
              mem_a <= '0;
              mem_wr <= 1'b0;
              r_hold <= 1'b0;
            end else begin
              r_k <= r_k + 3'd1;
              mem_a <= r_addr + 32'(r_k) + 32'd1;
              mem_dout <= r_wdata[{w_knext, 3'b000} +: 8];
            end
          end else begin
            // read data lags its address by one cycle
            if (r_k != 3'd0) rdata[{w_kprev, 3'b000} +: 8] <= mem_din;
            if (r_k == r_n) begin
              r_state <= DONE;
              done[r_ch] <= 1'b1;
              mem_a <= '0;
            end else begin
              r_k <= r_k + 3'd1;
              mem_a <= (r_k + 3'd1 == r_n) ? 32'd0 : r_addr + 32'(r_k) + 32'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_arbiter;
  localparam int NCH = 2;
  localparam int RUN = 3000;
  logic clk = 1'b0;
  logic rst, rdy, jump_flag, io_buffer_full, mem_wr;
  logic [NCH-1:0] req_valid, req_wr, done;
  logic [NCH*32-1:0] req_addr, req_wdata;
  logic [NCH*3-1:0] req_size;
  logic [31:0] rdata, mem_a;
  logic [7:0] mem_din, mem_dout;
  logic [7:0] ram [0:262143];
  logic [7:0] ref_mem [0:63];
  logic [NCH-1:0] hist [0:4095];
  logic [2:0] sz_tab [0:8];
  int passed = 0, total = 0, nfail = 0;

  mem_arbiter #(.NCH(NCH)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .done(done), .rdata(rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // byte RAM that pauses together with the rest of the system when rdy is low
  always @(posedge clk) begin
    if (rdy) begin
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
      mem_din <= ram[mem_a[17:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_req(input int ch, input logic v, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] sz);
    req_valid[ch] = v;
    req_wr[ch] = wr;
    req_addr[32*ch +: 32] = a;
    req_wdata[32*ch +: 32] = d;
    req_size[3*ch +: 3] = sz;
  endtask

  logic act [NCH];
  logic cwr [NCH];
  int coff [NCH], gap [NCH], ndone [NCH];
  logic [31:0] cdat [NCH];
  logic [2:0] csz [NCH];
  int n, gcyc, expg, w, last, prev, c;
  logic [31:0] expd;
  logic any_act;

  initial begin
    for (int a = 0; a < 262144; a++) ram[a] = 8'(a * 37 + 5);
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'((32'h400 + i) * 37 + 5);
    ram[18'h100] = 8'h11; ram[18'h101] = 8'h22; ram[18'h102] = 8'h33; ram[18'h103] = 8'h44;
    ram[18'h202] = 8'h5A;
    sz_tab = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd0, 3'd3, 3'd7, 3'd1, 3'd2};
    mem_din = 8'h00;
    rst = 1'b0; rdy = 1'b1; jump_flag = 1'b0; io_buffer_full = 1'b0;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_size = '0;
    #2 rst = 1'b1;
    tick; tick;
    chk("reset done", done, 0);
    chk("reset rdata", rdata, 0);
    chk("reset mem_a", mem_a, 0);
    chk("reset mem_dout", mem_dout, 0);
    chk("reset mem_wr", mem_wr, 0);
    rst = 1'b0;
    tick;

    // single 4-byte read
    set_req(0, 1, 0, 32'h100, 0, 3'd4);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("t1 mem_a", mem_a, 32'h100 + k);
      chk("t1 mem_wr", mem_wr, 0);
    end
    tick; chk("t1 no early done", done, 0);
    tick; chk("t1 done", done, 2'b01); chk("t1 rdata", rdata, 32'h44332211);
    set_req(0, 0, 0, 0, 0, 0);
    tick; chk("t1 done pulse", done, 0);

    // round-robin from rr=0: ch1 first
    set_req(0, 1, 0, 32'h100, 0, 3'd1);
    set_req(1, 1, 0, 32'h101, 0, 3'd1);
    tick; chk("t2 first grant addr", mem_a, 32'h101);
    tick;
    tick; chk("t2 done ch1", done, 2'b10); chk("t2 rdata ch1", rdata, 32'h22);
    set_req(1, 0, 0, 0, 0, 0);
    tick; chk("t2 idle gap", done, 0); chk("t2 idle mem_a", mem_a, 0);
    tick; chk("t2 second grant addr", mem_a, 32'h100);
    tick; chk("t2 no done", done, 0);
    tick; chk("t2 done ch0", done, 2'b01); chk("t2 rdata ch0", rdata, 32'h11);
    set_req(0, 0, 0, 0, 0, 0);
    tick;

    // halfword store
    set_req(1, 1, 1, 32'h200, 32'hAABBCCDD, 3'd2);
    tick; chk("t3 a0", mem_a, 32'h200); chk("t3 d0", mem_dout, 8'hDD); chk("t3 wr0", mem_wr, 1);
    tick; chk("t3 a1", mem_a, 32'h201); chk("t3 d1", mem_dout, 8'hCC); chk("t3 wr1", mem_wr, 1);
    tick; chk("t3 done", done, 2'b10); chk("t3 wr off", mem_wr, 0);
    set_req(1, 0, 0, 0, 0, 0);
    tick;
    chk("t3 ram200", ram[18'h200], 8'hDD);
    chk("t3 ram201", ram[18'h201], 8'hCC);
    chk("t3 ram202 untouched", ram[18'h202], 8'h5A);

    // IO back-pressure
    set_req(1, 1, 1, 32'h30000, 32'h41, 3'd1);
    io_buffer_full = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick; chk("t4 held", mem_wr, 0);
    end
    io_buffer_full = 1'b0;
    tick; chk("t4 wr", mem_wr, 1); chk("t4 addr", mem_a, 32'h30000); chk("t4 byte", mem_dout, 8'h41);
    tick; chk("t4 done", done, 2'b10); chk("t4 single write", mem_wr, 0);
    set_req(1, 0, 0, 0, 0, 0);
    tick;

    // jump_flag in IDLE suppresses a flushable read
    set_req(0, 1, 0, 32'h100, 0, 3'd1);
    jump_flag = 1'b1;
    tick; chk("t5 suppressed", mem_a, 0);
    jump_flag = 1'b0;
    tick; chk("t5 granted after", mem_a, 32'h100);
    tick;
    tick; chk("t5 done", done, 2'b01); chk("t5 rdata", rdata, 32'h11);
    set_req(0, 0, 0, 0, 0, 0);
    tick;

    // flush of an in-flight read
    set_req(0, 1, 0, 32'h100, 0, 3'd4);
    tick;
    tick; jump_flag = 1'b1; set_req(0, 0, 0, 0, 0, 0);
    tick; chk("t5 flush mem_a", mem_a, 0); chk("t5 flush mem_wr", mem_wr, 0); chk("t5 flush done", done, 0);
    jump_flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick; chk("t5 no done after flush", done, 0);
    end

    // writes ignore jump_flag
    set_req(1, 1, 1, 32'h210, 32'h01020304, 3'd4);
    jump_flag = 1'b1;
    tick; chk("t5w a0", mem_a, 32'h210); chk("t5w wr", mem_wr, 1);
    tick; tick;
    tick; chk("t5w a3", mem_a, 32'h213); chk("t5w d3", mem_dout, 8'h01);
    tick; chk("t5w done", done, 2'b10);
    set_req(1, 0, 0, 0, 0, 0); jump_flag = 1'b0;
    tick;
    chk("t5w ram", {ram[18'h213], ram[18'h212], ram[18'h211], ram[18'h210]}, 32'h01020304);

    // rdy freeze delays completion by the frozen cycles
    set_req(0, 1, 0, 32'h100, 0, 3'd4);
    tick;
    tick; rdy = 1'b0;
    tick; chk("t6 frozen wr", mem_wr, 0);
    tick;
    tick; rdy = 1'b1;
    tick; tick;
    tick; chk("t6 not yet", done, 0);
    tick; chk("t6 done", done, 2'b01); chk("t6 rdata", rdata, 32'h44332211);
    set_req(0, 0, 0, 0, 0, 0);
    tick;

    // async reset mid-write
    set_req(1, 1, 1, 32'h220, 32'h55667788, 3'd4);
    tick;
    tick; chk("t6r writing", mem_wr, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6r mem_wr", mem_wr, 0); chk("t6r mem_a", mem_a, 0); chk("t6r mem_dout", mem_dout, 0);
    chk("t6r done", done, 0); chk("t6r rdata", rdata, 0);
    set_req(1, 0, 0, 0, 0, 0);
    tick; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick; chk("t6r no done", done, 0);
    end

    // randomized traffic in 0x400..0x43F
    for (int g = 0; g < NCH; g++) begin act[g] = 0; gap[g] = 0; ndone[g] = 0; end
    last = 0; prev = -1;
    for (int t = 0; t < RUN + 300; t++) begin
      for (int g = 0; g < NCH; g++) begin
        if (done[g]) begin
          chk("rnd done owner", act[g], 1);
          n = (csz[g] == 3'd1) ? 1 : (csz[g] == 3'd2) ? 2 : 4;
          gcyc = t - (cwr[g] ? n + 1 : n + 2);
          expg = -1;
          for (int q = prev + 1; q < t; q++) if (expg < 0 && hist[q] != 0) expg = q;
          chk("rnd grant cycle", gcyc, expg);
          if (gcyc >= 0) begin
            w = -1;
            for (int j = 1; j <= NCH; j++) begin
              c = (last + j) % NCH;
              if (w < 0 && |(hist[gcyc] & (NCH'(1) << c))) w = c;
            end
            chk("rnd rr winner", g, w);
          end
          last = g; prev = t;
          if (cwr[g]) begin
            for (int b = 0; b < n; b++) ref_mem[coff[g] + b] = cdat[g][8*b +: 8];
          end else begin
            expd = 0;
            for (int b = 0; b < n; b++) expd[8*b +: 8] = ref_mem[coff[g] + b];
            chk("rnd rdata", rdata, expd);
          end
          act[g] = 0; req_valid[g] = 1'b0; gap[g] = $urandom_range(0, 3); ndone[g]++;
        end
      end
      any_act = 0;
      for (int g = 0; g < NCH; g++) begin
        if (!act[g]) begin
          if (gap[g] > 0) gap[g]--;
          else if (t < RUN) begin
            act[g] = 1;
            cwr[g] = 1'($urandom_range(0, 1));
            coff[g] = $urandom_range(0, 59);
            cdat[g] = $urandom;
            csz[g] = sz_tab[$urandom_range(0, 8)];
            set_req(g, 1, cwr[g], 32'h400 + coff[g], cdat[g], csz[g]);
          end
        end
        any_act |= act[g];
      end
      hist[t] = req_valid;
      if (t >= RUN && !any_act) break;
      tick;
    end
    chk("rnd drained", any_act, 0);
    for (int g = 0; g < NCH; g++) chk("rnd channel served", ndone[g] > 50, 1);
    for (int i = 0; i < 64; i++) chk("rnd ram image", ram[18'h400 + i], ref_mem[i]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
